// File: rtl/polytomsg_compress_pack.sv
// polytomsg_compress_pack: Kyber poly_tomsg 1-bit compression and LSB-first byte packing.
// Define POLYTOMSG_RANGE_CHECK_EN to flag accepted coefficients >= KYBER_Q on oRangeErr.
module polytomsg_compress_pack #(
    parameter int KYBER_N = 256,
    parameter int KYBER_Q = 3329,
    parameter int i_Width = 12
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iStart,
    input  logic [i_Width-1:0] iCoeff,
    input  logic               iCoeffValid,
    output logic               oCoeffReady,
    output logic [7:0]         oMsgByte,
    output logic               oMsgValid,
    input  logic               iMsgReady,
    output logic [4:0]         oMsgIdx,
    output logic               oBusy,
    output logic               oDone,
    output logic               oRangeErr
);
    localparam int CW = $clog2(KYBER_N) + 1;
    localparam logic [CW-1:0] N_C = CW'(KYBER_N);
    localparam logic [4:0] LAST_IDX = 5'(KYBER_N / 8 - 1);
    // round(2c/Q) is odd exactly on [ceil(Q/4), floor(3Q/4)], also for c >= Q
    localparam logic [i_Width-1:0] LO = i_Width'((KYBER_Q + 3) / 4);
    localparam logic [i_Width-1:0] HI = i_Width'((3 * KYBER_Q) / 4);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitcnt;
    logic [6:0]      r_shift;
    logic [7:0]      r_byte;
    logic            r_valid;
    logic [4:0]      r_idx;
    logic            w_ready, w_acc, w_hs, w_bit, w_start;

    assign w_start     = (r_state == IDLE) && iStart;
    assign w_ready     = (r_state == RUN) && (r_cnt < N_C) && (r_bitcnt != 3'd7 || !r_valid || iMsgReady);
    assign w_acc       = w_ready && iCoeffValid;
    assign w_hs        = r_valid && iMsgReady;
    assign w_bit       = (iCoeff >= LO) && (iCoeff <= HI);
    assign oCoeffReady = w_ready;
    assign oMsgByte    = r_byte;
    assign oMsgValid   = r_valid;
    assign oMsgIdx     = r_idx;
    assign oBusy       = r_state != IDLE;
    assign oDone       = r_state == DONE;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = iStart ? RUN : IDLE;
            RUN:     w_next = (w_hs && r_idx == LAST_IDX) ? DONE : RUN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
        end else begin
            if (w_start) begin
                r_cnt    <= '0;
                r_bitcnt <= '0;
                r_idx    <= '0;
            end
            if (w_acc) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_bitcnt == 3'd7) begin
                    r_byte   <= {w_bit, r_shift};
                    r_bitcnt <= '0;
                end else begin
                    r_shift  <= {w_bit, r_shift[6:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
            end
            if (w_hs) r_idx <= r_idx + 5'd1;
            // a fresh byte load wins over the handshake that retires the old one
            r_valid <= (w_acc && r_bitcnt == 3'd7) || (r_valid && !iMsgReady);
        end
    end

`ifdef POLYTOMSG_RANGE_CHECK_EN
    localparam logic [i_Width-1:0] Q_C = i_Width'(KYBER_Q);
    logic r_err;
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                     r_err <= 1'b0;
        else if (w_start)                r_err <= 1'b0;
        else if (w_acc && iCoeff >= Q_C) r_err <= 1'b1;
    end
    assign oRangeErr = r_err;
`else
    assign oRangeErr = 1'b0;
`endif
endmodule

// File: doc/polytomsg_compress_pack.md
# polytomsg_compress_pack

- Stage directly downstream of the conditional-subtract (csubq) stage in the Poly-to-Message path of Kyber512 decryption.
- Takes a stream of 256 reduced 12-bit coefficients and compresses each one to 1 bit: bit = ((c<<1) + Q/2) / Q & 1.
- Packs the bits LSB-first into the 32-byte message, which it delivers as a valid/ready byte stream to the message buffer that feeds re-encryption.

## Interface
Parameters:
- KYBER_N, 256, coefficients per polynomial; must be a multiple of 8.
- KYBER_Q, 3329, modulus.
- i_Width, 12, coefficient width.

Ports:
- iClk  input  1  clock; all state changes on its rising edge.
- iRst_n  input  1  reset, asynchronous assertion, active-low.
- iStart  input  1  one-cycle pulse that begins a polynomial; ignored unless IDLE.
- iCoeff  input  i_Width  coefficient from the csubq stage.
- iCoeffValid  input  1  iCoeff is valid.
- oCoeffReady  output  1  block accepts iCoeff this cycle.
- oMsgByte  output  8  packed message byte.
- oMsgValid  output  1  oMsgByte is valid.
- iMsgReady  input  1  downstream accepts the byte.
- oMsgIdx  output  5  index of the byte on oMsgByte (0..31).
- oBusy  output  1  high outside IDLE.
- oDone  output  1  one-cycle pulse after the final byte handshake.
- oRangeErr  output  1  sticky out-of-range flag; see Configuration.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE -> RUN on iStart. Entering RUN clears the coefficient counter (9 bits), bit counter (3 bits), byte index and oRangeErr.
  - RUN -> DONE on the handshake of byte KYBER_N/8-1.
  - DONE -> IDLE after one cycle. oDone=1 only in DONE.
- **Coefficient accept:** a coefficient is taken when oCoeffReady && iCoeffValid.
  - oCoeffReady = (state==RUN) && (coeffs accepted < KYBER_N) && (bitcnt!=7 || !oMsgValid || iMsgReady).
  - This is a combinational path from iMsgReady.
- **Compression rule:** bit=1 iff 833 <= c <= 2496, else 0.
  - This equals the formula above for every 12-bit input, including c >= Q.
  - No divider is allowed.
- **Packing:**
  - Coefficient 8j+k maps to bit k of byte j.
  - Bits 0..6 collect in a 7-bit shift register.
  - The 8th accepted bit loads {bit, shift[6:0]} into the oMsgByte register, sets oMsgValid, and clears bitcnt.
- **Output handshake:**
  - A byte transfers when oMsgValid && iMsgReady, after which oMsgIdx increments.
  - oMsgByte and oMsgIdx are held stable while oMsgValid && !iMsgReady.
  - Simultaneous byte handshake and 8th-bit load in the same cycle loads the new byte, keeps oMsgValid=1, and increments oMsgIdx.
- **Back-pressure:** accepting coefficients continues into the shift register while a byte is pending. Only the 8th bit of the next byte stalls.
- **Reset:** asserting iRst_n low at any time, including mid-polynomial, returns all state to reset values immediately. A partial message is discarded.

## Timing
- **Reset values:** state=IDLE, oCoeffReady=0, oMsgByte=8'h00, oMsgValid=0, oMsgIdx=0, oBusy=0, oDone=0, oRangeErr=0.
- **Start:** first oCoeffReady=1 one cycle after the iStart edge.
- **Byte latency:** oMsgValid rises the cycle after the 8th coefficient of a byte is accepted.
- **Throughput:** 1 coefficient/cycle with iMsgReady=1. A full polynomial takes 1 (start) + 256 + 1 (last byte) cycles, then oDone on the next cycle.
- **oBusy:** high from the cycle after iStart through the DONE cycle.

## Configuration
- **POLYTOMSG_RANGE_CHECK_EN defined:**
  - Any accepted coefficient with c >= KYBER_Q sets oRangeErr.
  - oRangeErr stays set until the next iStart or reset.
  - Packing is unaffected.
- **Not defined:** oRangeErr is tied to 0 and no comparator is built.

## Test plan
- **All zeros:** reset, iStart, 256 coefficients of 0 with iMsgReady=1 -> 32 bytes of 8'h00, oMsgIdx 0..31 in order, oDone pulse one cycle after byte 31.
- **Threshold boundaries:** coefficients cycling 832, 833, 2496, 2497, 0, 1664, 3328, 1665 -> every byte is 8'hA6 (bits LSB-first 0,1,1,0,0,1,0,1).
- **Back-pressure:**
  - All coefficients 1664 with iCoeffValid=1 and iMsgReady held 0 -> oCoeffReady drops while the 16th coefficient is presented; byte 0 = 8'hFF is held stable with oMsgIdx=0.
  - Releasing iMsgReady -> the stream resumes with no lost or duplicated bits.
- **Random stress:** random gaps on iCoeffValid/iMsgReady with random coefficients in 0..3328 -> bytes match the C poly_tomsg reference model, and iStart pulses during RUN are ignored.
- **Reset mid-operation:** iRst_n low after 100 coefficients -> all outputs at reset values. A new iStart then produces a correct full message from byte index 0.
- **With POLYTOMSG_RANGE_CHECK_EN:** one coefficient of 3329 at position 40 -> oRangeErr=1 from the next cycle through DONE, byte 5 bit 0 = 0. The next iStart clears oRangeErr.
